// File: rtl/mine_placer_if.sv
// Setup-control <-> mine placer bundle: run parameters in, placement and status out.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the placer is idle.
interface mine_placer_if #(
    parameter int ROWS   = 5,
    parameter int COLS   = 5,
    parameter int SEED_W = 16
);
    localparam int N     = ROWS * COLS;
    localparam int CNT_W = $clog2(N + 1);

    logic              in_start;
    logic [SEED_W-1:0] in_mult;
    logic [SEED_W-1:0] in_increment;
    logic [SEED_W-1:0] in_seed;
    logic [CNT_W-1:0]  in_mine_num;
    logic [N-1:0]      out_mines;
    logic              out_busy;
    logic              out_done;
    logic              out_error;

    modport master (
        output in_start, in_mult, in_increment, in_seed, in_mine_num,
        input  out_mines, out_busy, out_done, out_error
    );

    modport slave (
        input  in_start, in_mult, in_increment, in_seed, in_mine_num,
        output out_mines, out_busy, out_done, out_error
    );
endinterface

// File: rtl/mine_placer.sv
// LCG-driven placement of a requested number of distinct mines on a ROWS x COLS board.
// Latency: start edge k, CHECK at k+1, one candidate per edge from k+2; best case done after edge k+1+M.
// Backpressure: none; start is ignored while busy, a held start re-arms on the first idle cycle.
module mine_placer #(
    parameter int ROWS      = 5,
    parameter int COLS      = 5,
    parameter int SEED_W    = 16,
    parameter int MAX_TRIES = 1024
) (
    input  logic         in_clka,
    input  logic         in_reset,
    mine_placer_if.slave bus
);
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    localparam logic [IDX_W:0]   N_IDX   = (IDX_W + 1)'(N);
    localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N);
    localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);

    typedef enum logic [1:0] {IDLE, CHECK, GEN} state_t;

    state_t            state_q, state_nxt;
    logic [SEED_W-1:0] a_q, a_nxt;
    logic [SEED_W-1:0] c_q, c_nxt;
    logic [SEED_W-1:0] x_q, x_nxt;
    logic [CNT_W-1:0]  num_q, num_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [TRY_W-1:0]  try_q, try_nxt;
    logic [N-1:0]      mines_q, mines_nxt;
    logic              done_q, done_nxt;
    logic              err_q, err_nxt;

    // Product and sum are both kept at SEED_W bits, so the modulus is free.
    logic [SEED_W-1:0] prod;
    logic [SEED_W-1:0] x_gen;
    logic [IDX_W-1:0]  cand;
    logic              accept;
    logic [CNT_W-1:0]  cnt_inc;
    logic [TRY_W-1:0]  try_inc;

    assign prod    = a_q * x_q;
    assign x_gen   = prod + c_q;
    assign cand    = x_gen[SEED_W-1 -: IDX_W];
    assign accept  = ({1'b0, cand} < N_IDX) && !mines_q[cand];
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign try_inc = try_q + TRY_W'(1);

    always_ff @(negedge in_clka) begin
        if (in_reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            c_q     <= '0;
            x_q     <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            try_q   <= '0;
            mines_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            a_q     <= a_nxt;
            c_q     <= c_nxt;
            x_q     <= x_nxt;
            num_q   <= num_nxt;
            cnt_q   <= cnt_nxt;
            try_q   <= try_nxt;
            mines_q <= mines_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        a_nxt     = a_q;
        c_nxt     = c_q;
        x_nxt     = x_q;
        num_nxt   = num_q;
        cnt_nxt   = cnt_q;
        try_nxt   = try_q;
        mines_nxt = mines_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_start) begin
                    a_nxt     = bus.in_mult;
                    c_nxt     = bus.in_increment;
                    x_nxt     = bus.in_seed;
                    num_nxt   = bus.in_mine_num;
                    cnt_nxt   = '0;
                    try_nxt   = '0;
                    mines_nxt = '0;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (num_q > N_CNT) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (num_q == '0) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = GEN;
                end
            end
            GEN: begin
                x_nxt   = x_gen;
                try_nxt = try_inc;
                if (accept) begin
                    mines_nxt[cand] = 1'b1;
                    cnt_nxt         = cnt_inc;
                end
                // Completion wins over timeout when both land on the same edge.
                if (accept && (cnt_inc == num_q)) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (try_inc == TRY_MAX) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.out_mines = mines_q;
    assign bus.out_busy  = (state_q != IDLE);
    assign bus.out_done  = done_q;
    assign bus.out_error = err_q;
endmodule

// File: tb/tb_mine_placer.sv
// Randomized and directed runs of mine_placer against a run-level trace model.
module tb_mine_placer;
    localparam int ROWS      = 5;
    localparam int COLS      = 5;
    localparam int SEED_W    = 16;
    localparam int MAX_TRIES = 1024;
    localparam int N         = ROWS * COLS;
    localparam int IDX_W     = $clog2(N);

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         err;
        logic [N-1:0] mines;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mine_placer_if #(.ROWS(ROWS), .COLS(COLS), .SEED_W(SEED_W)) bus ();

    mine_placer #(.ROWS(ROWS), .COLS(COLS), .SEED_W(SEED_W), .MAX_TRIES(MAX_TRIES)) dut (
        .in_clka  (clk),
        .in_reset (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    logic         chk_en = 1'b0;
    obs_t         exp_q[$];
    logic [N-1:0] last_mines = '0;
    logic [N-1:0] dut_done_mines = '0;
    obs_t         e_cur;
    obs_t         g_cur;

    // Expected per-cycle observation for one run, derived from the game rules:
    // one CHECK cycle, then (for a valid request) one settling GEN cycle and one candidate per cycle.
    function automatic void build_trace(input int a, input int c, input int s, input int m,
                                        output int len, output logic [N-1:0] fin);
        longint       x = s;
        int           cnt = 0;
        int           cand;
        logic [N-1:0] mines = '0;
        len = 0;
        exp_q.push_back({3'b100, mines}); len++;
        if (m > N) begin
            exp_q.push_back({3'b001, mines}); len++;
        end else if (m == 0) begin
            exp_q.push_back({3'b010, mines}); len++;
        end else begin
            exp_q.push_back({3'b100, mines}); len++;
            for (int t = 1; t <= MAX_TRIES; t++) begin
                x    = (longint'(a) * x + longint'(c)) % 65536;
                cand = int'(x) / (1 << (SEED_W - IDX_W));
                if (cand < N && !mines[cand]) begin
                    mines[cand] = 1'b1;
                    cnt++;
                end
                if (cnt == m) begin
                    exp_q.push_back({3'b010, mines}); len++;
                    break;
                end
                if (t == MAX_TRIES) begin
                    exp_q.push_back({3'b001, mines}); len++;
                    break;
                end
                exp_q.push_back({3'b100, mines}); len++;
            end
        end
        fin        = mines;
        last_mines = mines;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (chk_en) begin
            if (exp_q.size() > 0) e_cur = exp_q.pop_front();
            else                  e_cur = {3'b000, last_mines};
            g_cur = {bus.out_busy, bus.out_done, bus.out_error, bus.out_mines};
            total++;
            if (g_cur !== e_cur) begin
                bad++;
                $display("FAIL cycle %0d outputs: got busy/done/err=%b mines=%h, expected busy/done/err=%b mines=%h",
                         cyc, g_cur[N+2:N], g_cur.mines, e_cur[N+2:N], e_cur.mines);
            end
            if (bus.out_done === 1'b1) dut_done_mines = bus.out_mines;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic set_inputs(input int a, input int c, input int s, input int m);
        bus.in_mult      = SEED_W'(a);
        bus.in_increment = SEED_W'(c);
        bus.in_seed      = SEED_W'(s);
        bus.in_mine_num  = 5'(m);
    endtask

    // Launch one run, register its trace after the start edge, and wait until it has drained.
    task automatic do_run(input int a, input int c, input int s, input int m,
                          output int len, output logic [N-1:0] fin);
        @(posedge clk); #1;
        set_inputs(a, c, s, m);
        bus.in_start = 1'b1;
        @(negedge clk); #1;
        bus.in_start = 1'b0;
        build_trace(a, c, s, m, len, fin);
        repeat (len) @(negedge clk);
    endtask

    int           len, len2;
    logic [N-1:0] fin, fin2;
    logic [N-1:0] rand_first;
    int           ra, rc, rs, rm;

    initial begin
        bus.in_start = 1'b0;
        set_inputs(0, 0, 0, 0);
        @(negedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        // Deterministic sequence 1,2,3.
        do_run(1, 16'h0800, 0, 3, len, fin);
        check("det_mines_model", 32'(fin), 32'h0000000E);
        check("det_len_model", 32'(len), 32'd5);

        // Duplicate rejection until timeout.
        do_run(1, 0, 0, 2, len, fin);
        check("timeout_mines_model", 32'(fin), 32'h00000001);
        check("timeout_len_model", 32'(len), 32'd1026);

        // Range rejection 31..25, then cell 24.
        do_run(1, 16'hF800, 0, 1, len, fin);
        check("range_mines_model", 32'(fin), 32'h01000000);
        check("range_len_model", 32'(len), 32'd10);

        // Bad requests.
        do_run(1, 0, 0, 26, len, fin);
        check("over_len_model", 32'(len), 32'd2);
        do_run(1, 0, 0, 0, len, fin);
        check("zero_len_model", 32'(len), 32'd2);

        // Back-to-back runs with start held high across the first pulse.
        @(posedge clk); #1;
        set_inputs(1, 16'h0800, 0, 2);
        bus.in_start = 1'b1;
        @(negedge clk); #1;
        build_trace(1, 16'h0800, 0, 2, len, fin);
        set_inputs(1, 16'hF800, 0, 1);
        build_trace(1, 16'hF800, 0, 1, len2, fin2);
        repeat (len) @(negedge clk);
        #1 bus.in_start = 1'b0;
        repeat (len2) @(negedge clk);
        check("b2b_first_model", 32'(fin), 32'h00000006);

        // Full random run, then the same run aborted by reset, then repeated.
        do_run(25173, 13849, 16'h1234, 10, len, fin);
        rand_first = dut_done_mines;
        check("rand_popcount", 32'($countones(rand_first)), 32'd10);
        check("rand_exact", 32'(rand_first), 32'(fin));

        @(posedge clk); #1;
        set_inputs(25173, 13849, 16'h1234, 10);
        bus.in_start = 1'b1;
        @(negedge clk); #1;
        bus.in_start = 1'b0;
        build_trace(25173, 13849, 16'h1234, 10, len, fin);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        last_mines = '0;
        @(posedge clk); #1;
        check("reset_busy", 32'(bus.out_busy), 32'd0);
        check("reset_mines", 32'(bus.out_mines), 32'd0);
        rst = 1'b0;
        dut_done_mines = '0;
        do_run(25173, 13849, 16'h1234, 10, len, fin);
        check("rand_repro", 32'(dut_done_mines), 32'(rand_first));

        // Randomized runs, including invalid and timing-out requests.
        for (int i = 0; i < 8; i++) begin
            ra = int'($urandom_range(0, 65535));
            rc = int'($urandom_range(0, 65535));
            rs = int'($urandom_range(0, 65535));
            rm = int'($urandom_range(0, 27));
            do_run(ra, rc, rs, rm, len, fin);
        end

        repeat (3) @(posedge clk);
        #1 check("trace_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
